// File: rtl/cam_pkg.sv
// Shared types and default sizes for the camera capture path.
package cam_pkg;

    // Capture FSM states.
    typedef enum logic [1:0] {
        WAIT_VS,
        VBLANK,
        FRAME
    } cam_state_e;

    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned PIX_W        = 16;
    localparam int unsigned COL_W        = 11;
    localparam int unsigned ROW_W        = 10;
    localparam int unsigned DEF_MAX_COLS = 640;
    localparam int unsigned DEF_MAX_ROWS = 480;

endpackage

// File: rtl/cam_in_sync.sv
// Aligned synchronizer for the camera bus plus edge flags for pclk, href and vsync.
module cam_in_sync
    import cam_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cam_pclk,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [BYTE_W-1:0] cam_d,
    output logic              href,
    output logic [BYTE_W-1:0] d,
    output logic              pclk_rise,
    output logic              href_rise,
    output logic              href_fall,
    output logic              vsync_rise,
    output logic              vsync_fall
);

    localparam int unsigned BUS_W   = BYTE_W + 3;
    localparam int unsigned PCLK_B  = BYTE_W + 2;
    localparam int unsigned VSYNC_B = BYTE_W + 1;
    localparam int unsigned HREF_B  = BYTE_W;

    logic [BUS_W-1:0] chain_q [SYNC_STAGES];
    logic [BUS_W-1:0] cur_q;
    logic [2:0]       prev_q;   // {pclk, vsync, href} one cycle older than cur_q

    // Whole bus shifts together so control and data stay mutually aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                chain_q[i] <= '0;
            end
            cur_q  <= '0;
            prev_q <= '0;
        end else begin
            chain_q[0] <= {cam_pclk, cam_vsync, cam_href, cam_d};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain_q[i] <= chain_q[i-1];
            end
            cur_q  <= chain_q[SYNC_STAGES-1];
            prev_q <= cur_q[PCLK_B:HREF_B];
        end
    end

    // Level outputs and edge flags from the last two aligned samples.
    always_comb begin
        href       = cur_q[HREF_B];
        d          = cur_q[BYTE_W-1:0];
        pclk_rise  = cur_q[PCLK_B] & ~prev_q[2];
        vsync_rise = cur_q[VSYNC_B] & ~prev_q[1];
        vsync_fall = ~cur_q[VSYNC_B] & prev_q[1];
        href_rise  = cur_q[HREF_B] & ~prev_q[0];
        href_fall  = ~cur_q[HREF_B] & prev_q[0];
    end

endmodule

// File: rtl/cam_pixel_capture.sv
// Captures byte pairs from an OV7670-style camera bus into 16-bit pixels with position tracking.
module cam_pixel_capture #(
    parameter int unsigned DATA_W      = cam_pkg::PIX_W,
    parameter int unsigned ADDR_W      = cam_pkg::COL_W,
    parameter int unsigned ROW_W       = cam_pkg::ROW_W,
    parameter int unsigned MAX_COLS    = cam_pkg::DEF_MAX_COLS,
    parameter int unsigned MAX_ROWS    = cam_pkg::DEF_MAX_ROWS,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              cam_pclk,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_d,
    output logic [DATA_W-1:0] P_DTA,
    output logic              VLD_PIXEL,
    output logic [ADDR_W-1:0] o_col,
    output logic [ROW_W-1:0]  o_row,
    output logic              o_line_done,
    output logic              o_frame_done,
    output logic              o_err
);

    import cam_pkg::*;

    localparam logic [ADDR_W-1:0] COL_LIM = ADDR_W'(MAX_COLS);
    localparam logic [ROW_W-1:0]  ROW_LIM = ROW_W'(MAX_ROWS);

    logic              s_href;
    logic [BYTE_W-1:0] s_d;
    logic              pclk_rise, href_rise, href_fall, vsync_rise, vsync_fall;

    cam_state_e        state_q, state_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              phase_q, phase_d;
    logic [BYTE_W-1:0] hi_q, hi_d;
    logic              line_act_q, line_act_d;  // saw href rise inside this frame
    logic [DATA_W-1:0] pdta_q, pdta_d;
    logic              vld_q, vld_d;
    logic [ADDR_W-1:0] ocol_q, ocol_d;
    logic              line_done_q, line_done_d;
    logic              frame_done_q, frame_done_d;
    logic              err_q, err_d;

    cam_in_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (i_clk),
        .rst        (i_rst),
        .cam_pclk   (cam_pclk),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_d      (cam_d),
        .href       (s_href),
        .d          (s_d),
        .pclk_rise  (pclk_rise),
        .href_rise  (href_rise),
        .href_fall  (href_fall),
        .vsync_rise (vsync_rise),
        .vsync_fall (vsync_fall)
    );

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= WAIT_VS;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, byte assembly and line/frame bookkeeping.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        phase_d      = phase_q;
        hi_d         = hi_q;
        line_act_d   = line_act_q;
        pdta_d       = pdta_q;
        vld_d        = 1'b0;
        ocol_d       = ocol_q;
        line_done_d  = 1'b0;
        frame_done_d = 1'b0;
        err_d        = err_q;
        unique case (state_q)
            WAIT_VS: begin
                if (vsync_rise) state_d = VBLANK;
            end
            VBLANK: begin
                if (vsync_fall) begin
                    state_d    = FRAME;
                    row_d      = '0;
                    col_d      = '0;
                    phase_d    = 1'b0;
                    line_act_d = 1'b0;
                end
            end
            FRAME: begin
                if (href_rise) line_act_d = 1'b1;
                // A line already in progress at frame entry is ignored until href rises.
                if (pclk_rise && s_href && (line_act_q || href_rise)) begin
                    if (!phase_q) begin
                        hi_d    = s_d;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (row_q == ROW_LIM || col_q == COL_LIM) begin
                            err_d = 1'b1;
                        end else begin
                            vld_d  = 1'b1;
                            pdta_d = DATA_W'({hi_q, s_d});
                            ocol_d = col_q;
                            col_d  = col_q + 1'b1;
                        end
                    end
                end
                // Line end is evaluated before frame end so both pulses can coincide.
                if (href_fall && line_act_q) begin
                    if (phase_q) err_d = 1'b1;
                    if (col_q != '0 && row_q != ROW_LIM) begin
                        line_done_d = 1'b1;
                        row_d       = row_q + 1'b1;
                    end
                    col_d      = '0;
                    phase_d    = 1'b0;
                    line_act_d = 1'b0;
                end
                if (vsync_rise) begin
                    frame_done_d = 1'b1;
                    state_d      = VBLANK;
                    col_d        = '0;
                    phase_d      = 1'b0;
                    line_act_d   = 1'b0;
                end
            end
            default: state_d = WAIT_VS;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_q        <= '0;
            row_q        <= '0;
            phase_q      <= 1'b0;
            hi_q         <= '0;
            line_act_q   <= 1'b0;
            pdta_q       <= '0;
            vld_q        <= 1'b0;
            ocol_q       <= '0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            line_act_q   <= line_act_d;
            pdta_q       <= pdta_d;
            vld_q        <= vld_d;
            ocol_q       <= ocol_d;
            line_done_q  <= line_done_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign P_DTA        = pdta_q;
    assign VLD_PIXEL    = vld_q;
    assign o_col        = ocol_q;
    assign o_row        = row_q;
    assign o_line_done  = line_done_q;
    assign o_frame_done = frame_done_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Directed bench for cam_pixel_capture with small line/frame limits.
module tb_cam_pixel_capture;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        cam_pclk, cam_vsync, cam_href;
    logic [7:0]  cam_d;
    logic [15:0] P_DTA;
    logic        VLD_PIXEL;
    logic [10:0] o_col;
    logic [9:0]  o_row;
    logic        o_line_done, o_frame_done, o_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor state
    logic [15:0] mon_pix[$];
    logic [10:0] mon_col[$];
    int          n_ld = 0, n_fd = 0, n_both = 0, n_b2b = 0;
    logic        vld_prev = 1'b0;

    cam_pixel_capture #(
        .DATA_W      (16),
        .ADDR_W      (11),
        .ROW_W       (10),
        .MAX_COLS    (4),
        .MAX_ROWS    (4),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .cam_pclk     (cam_pclk),
        .cam_vsync    (cam_vsync),
        .cam_href     (cam_href),
        .cam_d        (cam_d),
        .P_DTA        (P_DTA),
        .VLD_PIXEL    (VLD_PIXEL),
        .o_col        (o_col),
        .o_row        (o_row),
        .o_line_done  (o_line_done),
        .o_frame_done (o_frame_done),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    // Record strobes and pulses just after each rising edge.
    always begin
        @(posedge i_clk);
        #1;
        if (VLD_PIXEL) begin
            mon_pix.push_back(P_DTA);
            mon_col.push_back(o_col);
            if (vld_prev) n_b2b++;
        end
        vld_prev = VLD_PIXEL;
        if (o_line_done) n_ld++;
        if (o_frame_done) n_fd++;
        if (o_line_done && o_frame_done) n_both++;
    end

    task automatic clear_mon();
        mon_pix.delete();
        mon_col.delete();
        n_ld = 0;
        n_fd = 0;
        n_both = 0;
    endtask

    task automatic cam_byte(input logic [7:0] b);
        @(negedge i_clk);
        cam_d = b;
        cam_pclk = 1'b0;
        repeat (3) @(negedge i_clk);
        cam_pclk = 1'b1;
        repeat (4) @(negedge i_clk);
    endtask

    task automatic href_start();
        @(negedge i_clk);
        cam_href = 1'b1;
        repeat (4) @(negedge i_clk);
    endtask

    task automatic href_end();
        @(negedge i_clk);
        cam_href = 1'b0;
        repeat (8) @(negedge i_clk);
    endtask

    task automatic start_frame();
        @(negedge i_clk);
        cam_vsync = 1'b1;
        repeat (10) @(negedge i_clk);
        cam_vsync = 1'b0;
        repeat (10) @(negedge i_clk);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        cam_vsync = 1'b0;
        cam_href = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
    endtask

    task automatic line_of_pixels(input int n, input logic [7:0] base);
        href_start();
        for (int i = 0; i < n; i++) begin
            cam_byte(base + 8'(2 * i));
            cam_byte(base + 8'(2 * i + 1));
        end
        href_end();
    endtask

    task automatic test_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        cam_pclk = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_d = 8'h00;
        repeat (3) @(posedge i_clk);
        #1;
        n_checks++; if (P_DTA !== 16'h0) begin n_fail++; $display("FAIL reset_pdta: got %h need 0000", P_DTA); end
        n_checks++; if (VLD_PIXEL !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b need 0", VLD_PIXEL); end
        n_checks++; if (o_col !== 11'd0) begin n_fail++; $display("FAIL reset_col: got %0d need 0", o_col); end
        n_checks++; if (o_row !== 10'd0) begin n_fail++; $display("FAIL reset_row: got %0d need 0", o_row); end
        n_checks++; if (o_line_done !== 1'b0) begin n_fail++; $display("FAIL reset_ld: got %b need 0", o_line_done); end
        n_checks++; if (o_frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b need 0", o_frame_done); end
        n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b need 0", o_err); end
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
    endtask

    task automatic test_basic_line();
        start_frame();
        clear_mon();
        n_checks++; if (o_row !== 10'd0) begin n_fail++; $display("FAIL basic_row_before: got %0d need 0", o_row); end
        href_start();
        cam_byte(8'hFF); cam_byte(8'hFE); cam_byte(8'h67);
        cam_byte(8'h68); cam_byte(8'h07); cam_byte(8'h06);
        href_end();
        n_checks++; if (mon_pix.size() !== 3) begin n_fail++; $display("FAIL basic_count: got %0d need 3", mon_pix.size()); end
        n_checks++; if (mon_pix[0] !== 16'hFFFE) begin n_fail++; $display("FAIL basic_pix0: got %h need FFFE", mon_pix[0]); end
        n_checks++; if (mon_pix[1] !== 16'h6768) begin n_fail++; $display("FAIL basic_pix1: got %h need 6768", mon_pix[1]); end
        n_checks++; if (mon_pix[2] !== 16'h0706) begin n_fail++; $display("FAIL basic_pix2: got %h need 0706", mon_pix[2]); end
        n_checks++; if (mon_col[0] !== 11'd0) begin n_fail++; $display("FAIL basic_col0: got %0d need 0", mon_col[0]); end
        n_checks++; if (mon_col[1] !== 11'd1) begin n_fail++; $display("FAIL basic_col1: got %0d need 1", mon_col[1]); end
        n_checks++; if (mon_col[2] !== 11'd2) begin n_fail++; $display("FAIL basic_col2: got %0d need 2", mon_col[2]); end
        n_checks++; if (n_ld !== 1) begin n_fail++; $display("FAIL basic_line_done: got %0d need 1", n_ld); end
        n_checks++; if (o_row !== 10'd1) begin n_fail++; $display("FAIL basic_row_after: got %0d need 1", o_row); end
        n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b need 0", o_err); end
    endtask

    task automatic test_latency();
        int  lat;
        logic seen;
        clear_mon();
        href_start();
        cam_byte(8'h12);
        @(negedge i_clk);
        cam_d = 8'h34;
        cam_pclk = 1'b0;
        repeat (3) @(negedge i_clk);
        cam_pclk = 1'b1;
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge i_clk);
            #1;
            lat++;
            if (VLD_PIXEL) seen = 1'b1;
        end
        repeat (4) @(negedge i_clk);
        href_end();
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL latency: got %0d cycles need 4", lat); end
        n_checks++; if (mon_pix[0] !== 16'h1234) begin n_fail++; $display("FAIL latency_pix: got %h need 1234", mon_pix[0]); end
        n_checks++; if (o_row !== 10'd2) begin n_fail++; $display("FAIL latency_row: got %0d need 2", o_row); end
    endtask

    task automatic test_odd_bytes();
        clear_mon();
        href_start();
        cam_byte(8'hAA); cam_byte(8'hBB); cam_byte(8'hCC);
        href_end();
        n_checks++; if (mon_pix.size() !== 1) begin n_fail++; $display("FAIL odd_count: got %0d need 1", mon_pix.size()); end
        n_checks++; if (mon_pix[0] !== 16'hAABB) begin n_fail++; $display("FAIL odd_pix: got %h need AABB", mon_pix[0]); end
        n_checks++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL odd_err: got %b need 1", o_err); end
        n_checks++; if (n_ld !== 1) begin n_fail++; $display("FAIL odd_line_done: got %0d need 1", n_ld); end
    endtask

    task automatic test_col_overflow();
        do_reset();
        start_frame();
        clear_mon();
        line_of_pixels(6, 8'h10);
        n_checks++; if (mon_pix.size() !== 4) begin n_fail++; $display("FAIL colov_count: got %0d need 4", mon_pix.size()); end
        n_checks++; if (mon_col[3] !== 11'd3) begin n_fail++; $display("FAIL colov_last_col: got %0d need 3", mon_col[3]); end
        n_checks++; if (mon_pix[3] !== 16'h1617) begin n_fail++; $display("FAIL colov_last_pix: got %h need 1617", mon_pix[3]); end
        n_checks++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL colov_err: got %b need 1", o_err); end
        n_checks++; if (n_ld !== 1) begin n_fail++; $display("FAIL colov_line_done: got %0d need 1", n_ld); end
    endtask

    task automatic test_row_overflow();
        do_reset();
        start_frame();
        for (int l = 0; l < 4; l++) line_of_pixels(1, 8'h20);
        n_checks++; if (o_row !== 10'd4) begin n_fail++; $display("FAIL rowov_row: got %0d need 4", o_row); end
        n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL rowov_err_early: got %b need 0", o_err); end
        clear_mon();
        line_of_pixels(1, 8'h30);
        n_checks++; if (mon_pix.size() !== 0) begin n_fail++; $display("FAIL rowov_count: got %0d need 0", mon_pix.size()); end
        n_checks++; if (n_ld !== 0) begin n_fail++; $display("FAIL rowov_line_done: got %0d need 0", n_ld); end
        n_checks++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL rowov_err: got %b need 1", o_err); end
        n_checks++; if (o_row !== 10'd4) begin n_fail++; $display("FAIL rowov_row_hold: got %0d need 4", o_row); end
    endtask

    task automatic test_frame_end();
        do_reset();
        start_frame();
        clear_mon();
        line_of_pixels(2, 8'h40);
        href_start();
        cam_byte(8'h50); cam_byte(8'h51); cam_byte(8'h52); cam_byte(8'h53);
        // href fall and vsync rise on the same cycle
        @(negedge i_clk);
        cam_href = 1'b0;
        cam_vsync = 1'b1;
        repeat (10) @(negedge i_clk);
        n_checks++; if (n_ld !== 2) begin n_fail++; $display("FAIL fend_line_done: got %0d need 2", n_ld); end
        n_checks++; if (n_fd !== 1) begin n_fail++; $display("FAIL fend_frame_done: got %0d need 1", n_fd); end
        n_checks++; if (n_both !== 1) begin n_fail++; $display("FAIL fend_coincide: got %0d need 1", n_both); end
        n_checks++; if (o_row !== 10'd2) begin n_fail++; $display("FAIL fend_row_hold: got %0d need 2", o_row); end
        cam_vsync = 1'b0;
        repeat (10) @(negedge i_clk);
        n_checks++; if (o_row !== 10'd0) begin n_fail++; $display("FAIL fend_row_restart: got %0d need 0", o_row); end
        clear_mon();
        line_of_pixels(1, 8'h60);
        n_checks++; if (mon_col[0] !== 11'd0) begin n_fail++; $display("FAIL fend_col_restart: got %0d need 0", mon_col[0]); end
        n_checks++; if (mon_pix[0] !== 16'h6061) begin n_fail++; $display("FAIL fend_pix: got %h need 6061", mon_pix[0]); end
        n_checks++; if (n_fd !== 0) begin n_fail++; $display("FAIL fend_no_extra_fd: got %0d need 0", n_fd); end
    endtask

    task automatic test_mid_frame_start();
        @(negedge i_clk);
        i_rst = 1'b1;
        cam_vsync = 1'b0;
        cam_href = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        clear_mon();
        cam_byte(8'h71); cam_byte(8'h72); cam_byte(8'h73); cam_byte(8'h74);
        href_end();
        line_of_pixels(2, 8'h80);
        n_checks++; if (mon_pix.size() !== 0) begin n_fail++; $display("FAIL midstart_count: got %0d need 0", mon_pix.size()); end
        n_checks++; if (n_ld !== 0) begin n_fail++; $display("FAIL midstart_line_done: got %0d need 0", n_ld); end
        start_frame();
        href_start();
        cam_byte(8'h5A); cam_byte(8'hA5);
        href_end();
        n_checks++; if (mon_pix.size() !== 1) begin n_fail++; $display("FAIL midstart_after_count: got %0d need 1", mon_pix.size()); end
        n_checks++; if (mon_pix[0] !== 16'h5AA5) begin n_fail++; $display("FAIL midstart_after_pix: got %h need 5AA5", mon_pix[0]); end
    endtask

    task automatic test_reset_mid_line();
        do_reset();
        start_frame();
        line_of_pixels(2, 8'h90);
        clear_mon();
        href_start();
        cam_byte(8'hC1);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        n_checks++; if (VLD_PIXEL !== 1'b0) begin n_fail++; $display("FAIL rstmid_vld: got %b need 0", VLD_PIXEL); end
        n_checks++; if (P_DTA !== 16'h0) begin n_fail++; $display("FAIL rstmid_pdta: got %h need 0000", P_DTA); end
        n_checks++; if (o_col !== 11'd0) begin n_fail++; $display("FAIL rstmid_col: got %0d need 0", o_col); end
        n_checks++; if (o_row !== 10'd0) begin n_fail++; $display("FAIL rstmid_row: got %0d need 0", o_row); end
        @(negedge i_clk);
        i_rst = 1'b0;
        cam_byte(8'hC2);
        href_end();
        line_of_pixels(1, 8'hD0);
        n_checks++; if (mon_pix.size() !== 0) begin n_fail++; $display("FAIL rstmid_no_strobe: got %0d need 0", mon_pix.size()); end
        n_checks++; if (n_ld !== 0) begin n_fail++; $display("FAIL rstmid_no_ld: got %0d need 0", n_ld); end
        start_frame();
        line_of_pixels(1, 8'hE0);
        n_checks++; if (mon_pix[0] !== 16'hE0E1) begin n_fail++; $display("FAIL rstmid_resync_pix: got %h need E0E1", mon_pix[0]); end
        n_checks++; if (o_row !== 10'd1) begin n_fail++; $display("FAIL rstmid_resync_row: got %0d need 1", o_row); end
    endtask

    task automatic test_back_to_back();
        n_checks++; if (n_b2b !== 0) begin n_fail++; $display("FAIL back_to_back_vld: got %0d need 0", n_b2b); end
    endtask

    initial begin
        i_rst = 1'b1;
        cam_pclk = 1'b0;
        cam_vsync = 1'b0;
        cam_href = 1'b0;
        cam_d = 8'h00;
        test_reset();
        test_basic_line();
        test_latency();
        test_odd_bytes();
        test_col_overflow();
        test_row_overflow();
        test_frame_end();
        test_mid_frame_start();
        test_reset_mid_line();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_pixel_capture.md
Name: cam_pixel_capture

Overview:
- Upstream feeder for the RGB565 line buffer. Samples an 8-bit parallel camera bus (PCLK/VSYNC/HREF/D[7:0], OV7670-style) inside the system clock domain.
- Assembles byte pairs into 16-bit pixels and issues a one-cycle VLD_PIXEL strobe with the pixel on P_DTA, which connects directly to the buffer's write side.
- Also reports column/row position and line/frame completion for downstream control.

Parameters:
- DATA_W, 16, assembled pixel width (two camera bytes).
- ADDR_W, 11, column counter width; matches line-buffer RD_ADDR width.
- ROW_W, 10, row counter width.
- MAX_COLS, 640, pixels accepted per line; excess pixels are dropped.
- MAX_ROWS, 480, lines accepted per frame; excess lines are dropped.
- SYNC_STAGES, 2, synchronizer depth applied to all camera inputs.

Ports:
- i_clk, in, 1, system clock; must be at least 4x cam_pclk.
- i_rst, in, 1, synchronous reset, active-high.
- cam_pclk, in, 1, camera pixel clock, sampled as data.
- cam_vsync, in, 1, frame sync, high between frames.
- cam_href, in, 1, line valid.
- cam_d, in, 8, camera data byte.
- P_DTA, out, DATA_W, assembled pixel {first byte, second byte}.
- VLD_PIXEL, out, 1, one-cycle strobe; P_DTA valid.
- o_col, out, ADDR_W, column index of the pixel on P_DTA.
- o_row, out, ROW_W, current row index.
- o_line_done, out, 1, one-cycle pulse at end of an accepted line.
- o_frame_done, out, 1, one-cycle pulse at end of frame.
- o_err, out, 1, sticky: odd byte count in a line, or column/row overflow; cleared only by reset.

Behaviour:
- Reset, sampled on i_clk rising edge while i_rst=1: all outputs 0, FSM in WAIT_VS, synchronizers cleared, byte phase 0.
- Synchronization: cam_pclk, cam_vsync, cam_href and cam_d pass through the same SYNC_STAGES register chain, so they stay mutually aligned. pclk_rise = sync_pclk & ~sync_pclk_d. All decisions use the synchronized signals.
- FSM states:
  - WAIT_VS: wait for a vsync rising edge, so capture never starts mid-frame. Then go to VBLANK.
  - VBLANK: on vsync falling edge, go to FRAME with row=0.
  - FRAME: active frame. Each pclk_rise with href=1 captures one byte:
    - phase 0: latch byte into hi register; phase becomes 1.
    - phase 1: P_DTA <= {hi, byte}; VLD_PIXEL=1 for exactly one cycle; o_col <= col; col increments; phase becomes 0.
  - href falling edge in FRAME:
    - If phase=1: drop the partial byte and set o_err.
    - If col>0: o_line_done pulses and row increments.
    - col and phase return to 0.
  - vsync rising edge in FRAME: o_frame_done pulses one cycle; go to VBLANK; row is held until the next frame start.
- Latency: VLD_PIXEL asserts SYNC_STAGES+2 i_clk cycles after the cam_pclk rising edge that carries the second byte.
- Column overflow: when col == MAX_COLS, further pixels in that line are not strobed, col saturates and o_err is set. Line end is handled normally.
- Row overflow: when row == MAX_ROWS, lines are not strobed and o_line_done is suppressed until vsync; o_err is set.
- Simultaneous vsync rise and href fall: process the line end first (o_line_done), then o_frame_done in the same cycle. Both pulses may coincide.
- href already high on entry to FRAME: wait for an href rising edge; no partial line is captured.
- Reset mid-line: everything clears and capture resynchronizes via WAIT_VS. No stray VLD_PIXEL.
- VLD_PIXEL is never high on two consecutive cycles.

Decomposition:
- Shared package (cam_pkg):
  - state enum {WAIT_VS, VBLANK, FRAME}
  - constants PIX_W=16, COL_W=11, ROW_W=10, default MAX_COLS/MAX_ROWS
- Sub-module: cam_in_sync. It holds the SYNC_STAGES aligned register chain for {pclk, vsync, href, d[7:0]} and generates the pclk_rise, href_fall and vsync_rise/fall edge flags. The FSM and byte assembly stay in the top module.

Test Plan:
- Basic line: vsync pulse, then href high for 6 PCLK rising edges with bytes FF,FE,67,68,07,06. Required: 3 VLD_PIXEL strobes with P_DTA = FFFE, 6768, 0706 and o_col = 0,1,2; then one o_line_done; o_row goes 0→1.
- Odd byte count: href high for 3 bytes AA,BB,CC. Required: 1 strobe with P_DTA=AABB; CC is dropped; o_err=1; o_line_done pulses.
- Column overflow with MAX_COLS=4: send 6 pixels in one line. Required: exactly 4 strobes, o_col max 3, o_err=1.
- Mid-frame start: release reset while href is toggling and vsync is low. Required: no VLD_PIXEL until after a full vsync high→low sequence.
- Frame end: 2 lines of 2 pixels each, then vsync rises. Required: o_frame_done pulses once; the next frame starts at row 0, col 0.
- Reset mid-line: assert i_rst for 1 cycle after the first byte of a pixel. Required: all outputs 0 on the next cycle, no strobe for that pixel, FSM back in WAIT_VS.
